// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART TX state enum and constants; PAR state exists only with UART_TX_PARITY_EN
package uart_pkg;

    localparam int TICKS_PER_BIT = 16;
    localparam int TICK_W        = $clog2(TICKS_PER_BIT);

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PAR,
`endif
        STOP1,
        STOP2
    } tx_state_e;

    // Index of the last data bit for a word-length code (5..8 bits -> 4..7)
    function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
        return 3'd4 + {1'b0, wls};
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - character request and serial line signals of the UART transmitter
interface uart_tx_serializer_if;

    logic       CLKEN;
    logic       TXSTART;
    logic [7:0] DIN;
    logic [1:0] WLS;
    logic       STB;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       BC;
    logic       TXFINISHED;
    logic       BUSY;
    logic       SOUT;

    modport master (
        output CLKEN, TXSTART, DIN, WLS, STB, PEN, EPS, SP, BC,
        input  TXFINISHED, BUSY, SOUT
    );

    modport slave (
        input  CLKEN, TXSTART, DIN, WLS, STB, PEN, EPS, SP, BC,
        output TXFINISHED, BUSY, SOUT
    );

endinterface

// File: rtl/slib_tick_counter.sv
// rtl/slib_tick_counter.sv - enabled 16x baud tick counter with wrap pulse
module slib_tick_counter
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    // Hold at zero while cleared, otherwise count enabled ticks (natural wrap to 0)
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TICK_W'(1);
        end
    end

    // Tick count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap = en && !clr && (cnt_q == TICK_W'(TICKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer; parity support compiled in with UART_TX_PARITY_EN
module uart_tx_serializer
    import uart_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    uart_tx_serializer_if.slave  tx
);

    tx_state_e  state_q,  state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] din_q,    din_d;
    logic [1:0] wls_q,    wls_d;
    logic       stb_q,    stb_d;
    logic       sout_q,   sout_d;
    logic       txfin_q,  txfin_d;
    logic       tick_wrap;
`ifdef UART_TX_PARITY_EN
    logic       pen_q,    pen_d;
    logic       eps_q,    eps_d;
    logic       sp_q,     sp_d;
    logic [7:0] word_mask;
    logic       par_bit;

    // Parity over the captured word only; stick parity overrides with NOT EPS
    assign word_mask = 8'hFF >> (2'd3 - wls_q);
    assign par_bit   = sp_q ? ~eps_q : ((^(din_q & word_mask)) ^ ~eps_q);
`endif

    slib_tick_counter u_tick (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (state_q == IDLE),
        .en    (tx.CLKEN),
        .wrap  (tick_wrap)
    );

    // Frame sequencing: capture on start, advance one bit per tick-counter wrap
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        din_d    = din_q;
        wls_d    = wls_q;
        stb_d    = stb_q;
        txfin_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        pen_d    = pen_q;
        eps_d    = eps_q;
        sp_d     = sp_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx.TXSTART) begin
                    state_d  = START;
                    bitcnt_d = '0;
                    din_d    = tx.DIN;
                    wls_d    = tx.WLS;
                    stb_d    = tx.STB;
`ifdef UART_TX_PARITY_EN
                    pen_d    = tx.PEN;
                    eps_d    = tx.EPS;
                    sp_d     = tx.SP;
`endif
                end
            end
            START: begin
                if (tick_wrap) state_d = DATA;
            end
            DATA: begin
                if (tick_wrap) begin
                    if (bitcnt_q == last_bit_idx(wls_q)) begin
                        bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = pen_q ? PAR : STOP1;
`else
                        state_d  = STOP1;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PAR: begin
                if (tick_wrap) state_d = STOP1;
            end
`endif
            STOP1: begin
                if (tick_wrap) begin
                    if (stb_q) begin
                        state_d = STOP2;
                    end else begin
                        state_d = IDLE;
                        txfin_d = 1'b1;
                    end
                end
            end
            STOP2: begin
                if (tick_wrap) begin
                    state_d = IDLE;
                    txfin_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the current state; break forces the line low without touching the FSM
    always_comb begin
        sout_d = 1'b1;
        case (state_q)
            START:   sout_d = 1'b0;
            DATA:    sout_d = din_q[bitcnt_q];
`ifdef UART_TX_PARITY_EN
            PAR:     sout_d = par_bit;
`endif
            default: sout_d = 1'b1;
        endcase
        if (tx.BC) sout_d = 1'b0;
    end

    // State, capture and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            din_q    <= '0;
            wls_q    <= '0;
            stb_q    <= 1'b0;
            sout_q   <= 1'b1;
            txfin_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            pen_q    <= 1'b0;
            eps_q    <= 1'b0;
            sp_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            din_q    <= din_d;
            wls_q    <= wls_d;
            stb_q    <= stb_d;
            sout_q   <= sout_d;
            txfin_q  <= txfin_d;
`ifdef UART_TX_PARITY_EN
            pen_q    <= pen_d;
            eps_q    <= eps_d;
            sp_q     <= sp_d;
`endif
        end
    end

    assign tx.SOUT       = sout_q;
    assign tx.BUSY       = (state_q != IDLE);
    assign tx.TXFINISHED = txfin_q;

endmodule
